// File: rtl/simple_mem_responder.sv
// simple_mem_responder: fixed-latency imem/dmem responder sharing one word array
package simple_processor_pkg;
  parameter int ADDR_WIDTH = 16;
  parameter int DATA_WIDTH = 16;
endpackage

module simple_mem_responder #(
  parameter int MEM_ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
  parameter int MEM_DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int IMEM_LATENCY   = 1,
  parameter int DMEM_LATENCY   = 2
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic                      imem_req_i,
  input  logic [MEM_ADDR_WIDTH-1:0] imem_addr_i,
  output logic [MEM_DATA_WIDTH-1:0] imem_rdata_o,
  output logic                      imem_ack_o,
  input  logic                      dmem_req_i,
  input  logic                      dmem_we_i,
  input  logic [MEM_ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [MEM_DATA_WIDTH-1:0] dmem_wdata_i,
  output logic [MEM_DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                      dmem_ack_o
);
  localparam int OFS = $clog2(MEM_DATA_WIDTH / 8);
  localparam int DL  = MEM_DEPTH_LOG2;
  localparam int DW  = MEM_DATA_WIDTH;
  localparam int ICW = $clog2(IMEM_LATENCY + 1);
  localparam int DCW = $clog2(DMEM_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  state_t i_st, i_nx, d_st, d_nx;
  logic [ICW-1:0] i_cnt;
  logic [DCW-1:0] d_cnt;
  logic [DL-1:0] i_idx, d_idx, i_aidx, d_aidx;
  logic d_we, d_awe, i_acc, d_acc, i_go, d_go, addr_unused;
  logic [DW-1:0] d_wdata, d_awdata;
  logic [DW-1:0] mem [1<<DL];
  assign addr_unused = ^{imem_addr_i, dmem_addr_i};
  assign i_acc = i_st == IDLE && imem_req_i;
  assign d_acc = d_st == IDLE && dmem_req_i;
  assign i_go = i_nx == ACK;
  assign d_go = d_nx == ACK;
  assign imem_ack_o = i_st == ACK;
  assign dmem_ack_o = d_st == ACK;
  // With latency 1 the request enters ACK on its acceptance edge, so the access
  // takes the live inputs then and the captured copies otherwise.
  always_comb begin
    i_nx = i_acc ? (IMEM_LATENCY > 1 ? BUSY : ACK) : i_st == BUSY ? (i_cnt == '0 ? ACK : BUSY) : IDLE;
    d_nx = d_acc ? (DMEM_LATENCY > 1 ? BUSY : ACK) : d_st == BUSY ? (d_cnt == '0 ? ACK : BUSY) : IDLE;
    i_aidx = i_acc ? imem_addr_i[OFS+DL-1:OFS] : i_idx;
    d_aidx = d_acc ? dmem_addr_i[OFS+DL-1:OFS] : d_idx;
    d_awe = d_acc ? dmem_we_i : d_we;
    d_awdata = d_acc ? dmem_wdata_i : d_wdata;
  end
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      i_st <= IDLE;
      d_st <= IDLE;
      i_cnt <= '0;
      d_cnt <= '0;
      i_idx <= '0;
      d_idx <= '0;
      d_we <= 1'b0;
      d_wdata <= '0;
    end else begin
      i_st <= i_nx;
      d_st <= d_nx;
      i_cnt <= i_acc ? ICW'(IMEM_LATENCY - 2) : i_st == BUSY ? i_cnt - 1'b1 : i_cnt;
      d_cnt <= d_acc ? DCW'(DMEM_LATENCY - 2) : d_st == BUSY ? d_cnt - 1'b1 : d_cnt;
      if (i_acc) i_idx <= i_aidx;
      if (d_acc) begin
        d_idx <= d_aidx;
        d_we <= dmem_we_i;
        d_wdata <= dmem_wdata_i;
      end
    end
  end
  // Reads sample the array before a same-edge write lands.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int k = 0; k < (1 << DL); k++) mem[k] <= '0;
      imem_rdata_o <= '0;
      dmem_rdata_o <= '0;
    end else begin
      if (i_go) imem_rdata_o <= mem[i_aidx];
      if (d_go && !d_awe) dmem_rdata_o <= mem[d_aidx];
      if (d_go && d_awe) mem[d_aidx] <= d_awdata;
    end
  end
endmodule

// File: tb/tb_simple_mem_responder.sv
// tb_simple_mem_responder: table-driven dmem vectors plus hand-written timing sequences
module tb_simple_mem_responder;
  logic clk = 1'b0, arst_n = 1'b0;
  logic imem_req = 1'b0, dmem_req = 1'b0, dmem_we = 1'b0;
  logic [15:0] imem_addr = '0, dmem_addr = '0, dmem_wdata = '0;
  logic [15:0] imem_rdata, dmem_rdata, d3_imem_rdata, d3_dmem_rdata;
  logic imem_ack, dmem_ack, d3_imem_ack, d3_dmem_ack;
  int n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;

  simple_mem_responder dut (
    .clk_i(clk), .arst_ni(arst_n),
    .imem_req_i(imem_req), .imem_addr_i(imem_addr), .imem_rdata_o(imem_rdata), .imem_ack_o(imem_ack),
    .dmem_req_i(dmem_req), .dmem_we_i(dmem_we), .dmem_addr_i(dmem_addr), .dmem_wdata_i(dmem_wdata),
    .dmem_rdata_o(dmem_rdata), .dmem_ack_o(dmem_ack)
  );

  simple_mem_responder #(.DMEM_LATENCY(3)) d3 (
    .clk_i(clk), .arst_ni(arst_n),
    .imem_req_i(imem_req), .imem_addr_i(imem_addr), .imem_rdata_o(d3_imem_rdata), .imem_ack_o(d3_imem_ack),
    .dmem_req_i(dmem_req), .dmem_we_i(dmem_we), .dmem_addr_i(dmem_addr), .dmem_wdata_i(dmem_wdata),
    .dmem_rdata_o(d3_dmem_rdata), .dmem_ack_o(d3_dmem_ack)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Call right after a negedge; inputs are scrambled once accepted.
  task automatic dtxn(input bit sel, input logic we, input logic [15:0] a, input logic [15:0] wd,
                      output int lat, output logic [15:0] rd);
    dmem_req = 1'b1; dmem_we = we; dmem_addr = a; dmem_wdata = wd;
    @(negedge clk);
    dmem_req = 1'b0; dmem_we = ~we; dmem_addr = ~a; dmem_wdata = ~wd;
    lat = 1;
    while (!(sel ? d3_dmem_ack : dmem_ack) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = sel ? d3_dmem_rdata : dmem_rdata;
    @(negedge clk);
    chk("dmem_ack_pulse", {31'b0, sel ? d3_dmem_ack : dmem_ack}, 0);
  endtask

  task automatic itxn(input logic [15:0] a, output int lat, output logic [15:0] rd);
    imem_req = 1'b1; imem_addr = a;
    @(negedge clk);
    imem_req = 1'b0; imem_addr = ~a;
    lat = 1;
    while (!imem_ack && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = imem_rdata;
    @(negedge clk);
    chk("imem_ack_pulse", {31'b0, imem_ack}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [15:0] rd;
    tbl[0]  = '{1'b1, 16'h0010, 16'hA5A5, 16'h0000};
    tbl[1]  = '{1'b0, 16'h0010, 16'h0000, 16'hA5A5};
    tbl[2]  = '{1'b1, 16'h0011, 16'h5A5A, 16'hA5A5};
    tbl[3]  = '{1'b0, 16'h0010, 16'h0000, 16'h5A5A};
    tbl[4]  = '{1'b1, 16'h0806, 16'hBEEF, 16'h5A5A};
    tbl[5]  = '{1'b0, 16'h0006, 16'h0000, 16'hBEEF};
    tbl[6]  = '{1'b1, 16'h0000, 16'h1000, 16'hBEEF};
    tbl[7]  = '{1'b1, 16'h0002, 16'h1001, 16'hBEEF};
    tbl[8]  = '{1'b1, 16'h0004, 16'h1002, 16'hBEEF};
    tbl[9]  = '{1'b1, 16'h0007, 16'h1003, 16'hBEEF};
    tbl[10] = '{1'b0, 16'h0004, 16'h0000, 16'h1002};
    tbl[11] = '{1'b0, 16'h0806, 16'h0000, 16'h1003};
    repeat (2) @(negedge clk);
    chk("rst_imem_ack", {31'b0, imem_ack}, 0);
    chk("rst_dmem_ack", {31'b0, dmem_ack}, 0);
    chk("rst_imem_rdata", {16'b0, imem_rdata}, 0);
    chk("rst_dmem_rdata", {16'b0, dmem_rdata}, 0);
    chk("rst_d3_dmem_ack", {31'b0, d3_dmem_ack}, 0);
    arst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      dtxn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, rd);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 2);
      chk($sformatf("vec%0d_rdata", i), {16'b0, rd}, {16'b0, tbl[i].exp});
    end
    // imem streaming: req held high, ack every other cycle
    repeat (4) @(negedge clk);
    imem_req = 1'b1; imem_addr = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("stream%0d_ack", k), {31'b0, imem_ack}, 1);
      chk($sformatf("stream%0d_rdata", k), {16'b0, imem_rdata}, 32'h1000 + k);
      imem_addr = 16'(2 * (k + 1));
      @(negedge clk);
      chk($sformatf("stream%0d_gap", k), {31'b0, imem_ack}, 0);
    end
    imem_req = 1'b0;
    // dmem write and imem read of word 5 enter ACK on the same edge
    repeat (4) @(negedge clk);
    dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 16'h000A; dmem_wdata = 16'h1234;
    @(negedge clk);
    dmem_req = 1'b0; dmem_we = 1'b0;
    imem_req = 1'b1; imem_addr = 16'h000A;
    @(negedge clk);
    imem_req = 1'b0;
    chk("conf_imem_ack", {31'b0, imem_ack}, 1);
    chk("conf_dmem_ack", {31'b0, dmem_ack}, 1);
    chk("conf_imem_old", {16'b0, imem_rdata}, 0);
    chk("conf_dmem_keep", {16'b0, dmem_rdata}, 32'h1003);
    @(negedge clk);
    itxn(16'h000A, lat, rd);
    chk("conf_reread_lat", 32'(lat), 1);
    chk("conf_reread", {16'b0, rd}, 32'h1234);
    // latency 3, req dropped and addr changed after acceptance
    repeat (5) @(negedge clk);
    dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 16'h0020; dmem_wdata = 16'hCAFE;
    @(negedge clk);
    dmem_req = 1'b0; dmem_addr = 16'h0030; dmem_wdata = 16'hFFFF;
    chk("drop_ack_t1", {31'b0, d3_dmem_ack}, 0);
    @(negedge clk);
    chk("drop_ack_t2", {31'b0, d3_dmem_ack}, 0);
    @(negedge clk);
    chk("drop_ack_t3", {31'b0, d3_dmem_ack}, 1);
    @(negedge clk);
    dtxn(1, 1'b0, 16'h0020, 16'h0000, lat, rd);
    chk("drop_read_lat", 32'(lat), 3);
    chk("drop_committed", {16'b0, rd}, 32'hCAFE);
    dtxn(1, 1'b0, 16'h0030, 16'h0000, lat, rd);
    chk("drop_addr_ignored", {16'b0, rd}, 0);
    // reset while a write is in BUSY
    repeat (3) @(negedge clk);
    dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 16'h0040; dmem_wdata = 16'h7777;
    @(negedge clk);
    dmem_req = 1'b0;
    #1 arst_n = 1'b0;
    #1;
    chk("mid_rst_imem_rdata", {16'b0, imem_rdata}, 0);
    chk("mid_rst_dmem_rdata", {16'b0, dmem_rdata}, 0);
    chk("mid_rst_d3_dmem_rdata", {16'b0, d3_dmem_rdata}, 0);
    chk("mid_rst_imem_ack", {31'b0, imem_ack}, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("mid_rst_d3_ack%0d", k), {31'b0, d3_dmem_ack}, 0);
      chk($sformatf("mid_rst_ack%0d", k), {31'b0, dmem_ack}, 0);
    end
    arst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ack", {31'b0, dmem_ack | d3_dmem_ack}, 0);
    dtxn(0, 1'b1, 16'h0050, 16'h1111, lat, rd);
    dtxn(0, 1'b0, 16'h0050, 16'h0000, lat, rd);
    chk("post_rst_rw", {16'b0, rd}, 32'h1111);
    dtxn(0, 1'b0, 16'h0040, 16'h0000, lat, rd);
    chk("post_rst_uncommitted", {16'b0, rd}, 0);
    dtxn(0, 1'b0, 16'h0010, 16'h0000, lat, rd);
    chk("post_rst_cleared", {16'b0, rd}, 0);
    dtxn(1, 1'b0, 16'h0040, 16'h0000, lat, rd);
    chk("post_rst_d3_lat", 32'(lat), 3);
    chk("post_rst_d3_uncommitted", {16'b0, rd}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
